// File: rtl/serial_add_controller_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_controller_pkg
// Shared ALU package for the bit-serial add/subtract controller.
// Contents:
//   DEFAULT_WIDTH : default operand/result width in bits
//   sac_state_t   : controller FSM state encoding (IDLE, RUN, DONE)
// -----------------------------------------------------------------------------
package serial_add_controller_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sac_state_t;

endpackage : serial_add_controller_pkg

// File: rtl/serial_add_controller_adder.sv
// -----------------------------------------------------------------------------
// Single-bit adder cells used by the serial add controller.
//
// half_adder
//   a, b    : input  1  addend bits
//   sum     : output 1  a ^ b
//   carry   : output 1  a & b
//
// one_bit_full_adder
//   a, b    : input  1  addend bits
//   cin     : input  1  carry in
//   sum     : output 1  a ^ b ^ cin
//   cout    : output 1  carry out
//   Built from two half adders; the two half-adder carries can never both be
//   high, so an OR is enough to merge them.
// -----------------------------------------------------------------------------
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule : half_adder

module one_bit_full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic s0;
   logic c0;
   logic c1;

   half_adder u_ha0 (
      .a     (a),
      .b     (b),
      .sum   (s0),
      .carry (c0)
   );

   half_adder u_ha1 (
      .a     (s0),
      .b     (cin),
      .sum   (sum),
      .carry (c1)
   );

   assign cout = c0 | c1;

endmodule : one_bit_full_adder

// File: rtl/serial_add_controller.sv
// -----------------------------------------------------------------------------
// serial_add_controller
// Bit-serial adder/subtractor: one result bit per clock through a single
// shared full adder, LSB first. An operation takes WIDTH cycles in RUN plus
// one DONE cycle; with start_i held high a new operation is accepted every
// WIDTH+2 cycles.
//
// Parameters
//   WIDTH      : operand/result width in bits (2..32)
// Ports
//   clk_i      : input  1      clock, rising edge
//   rst_i      : input  1      asynchronous active-high reset
//   start_i    : input  1      start request, sampled only in IDLE
//   sub_i      : input  1      0 = A+B, 1 = A-B (sampled with start_i)
//   op_a_i     : input  WIDTH  operand A (sampled with start_i)
//   op_b_i     : input  WIDTH  operand B (sampled with start_i)
//   busy_o     : output 1      operation in progress (RUN or DONE)
//   done_o     : output 1      one-cycle pulse, result and flags valid
//   result_o   : output WIDTH  sum/difference, held until next completion
//   carry_o    : output 1      final carry out (subtract: 1 = no borrow)
//   overflow_o : output 1      signed overflow
//   zero_o     : output 1      result_o == 0
// -----------------------------------------------------------------------------
module serial_add_controller #(
   parameter int WIDTH = serial_add_controller_pkg::DEFAULT_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             sub_i,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             carry_o,
   output logic             overflow_o,
   output logic             zero_o
);

   import serial_add_controller_pkg::*;

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   sac_state_t       state_reg;
   sac_state_t       state_next;

   logic [WIDTH-1:0] a_sh_reg;
   logic [WIDTH-1:0] b_sh_reg;
   logic             c_reg;
   logic [CNT_W-1:0] cnt_reg;
   // Holds the WIDTH-1 sum bits produced so far; the final bit comes
   // straight from the adder on the last step, so result_o is untouched
   // until the whole word is ready.
   logic [WIDTH-2:0] psum_reg;

   logic [WIDTH-1:0] result_reg;
   logic             carry_reg;
   logic             overflow_reg;
   logic             zero_reg;

   logic             fa_sum;
   logic             fa_cout;
   logic [WIDTH-1:0] sum_word;
   logic             last_step;

   // The one and only adder cell; every bit position goes through it.
   one_bit_full_adder u_fa (
      .a    (a_sh_reg[0]),
      .b    (b_sh_reg[0]),
      .cin  (c_reg),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // New sum bit enters at the MSB, so after WIDTH shifts bit 0 is the LSB.
   assign sum_word  = {fa_sum, psum_reg};
   assign last_step = (cnt_reg == LAST_BIT);

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next state and status outputs
   always_comb begin
      state_next = state_reg;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start_i) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            busy_o = 1'b1;
            if (last_step) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            busy_o     = 1'b1;
            done_o     = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Datapath
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a_sh_reg     <= '0;
         b_sh_reg     <= '0;
         c_reg        <= 1'b0;
         cnt_reg      <= '0;
         psum_reg     <= '0;
         result_reg   <= '0;
         carry_reg    <= 1'b0;
         overflow_reg <= 1'b0;
         zero_reg     <= 1'b1;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start_i) begin
                  // Subtraction is A + ~B + 1: invert B and seed the carry.
                  a_sh_reg <= op_a_i;
                  b_sh_reg <= sub_i ? ~op_b_i : op_b_i;
                  c_reg    <= sub_i;
                  cnt_reg  <= '0;
               end
            end
            ST_RUN: begin
               a_sh_reg <= a_sh_reg >> 1;
               b_sh_reg <= b_sh_reg >> 1;
               c_reg    <= fa_cout;
               cnt_reg  <= cnt_reg + CNT_W'(1);
               psum_reg <= sum_word[WIDTH-1:1];
               if (last_step) begin
                  // On the MSB step c_reg is the carry into the MSB.
                  result_reg   <= sum_word;
                  carry_reg    <= fa_cout;
                  overflow_reg <= c_reg ^ fa_cout;
                  zero_reg     <= (sum_word == '0);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign result_o   = result_reg;
   assign carry_o    = carry_reg;
   assign overflow_o = overflow_reg;
   assign zero_o     = zero_reg;

endmodule : serial_add_controller
